// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative unsigned MUL/MULHU/DIVU/REMU sequencer
// Uses the shared pipeline ALU for every add/subtract; owns no adder itself.
module muldiv_sequencer #(
  parameter int          WIDTH   = 32,
  parameter logic [3:0]  SEL_ADD = 4'b0010,
  parameter logic [3:0]  SEL_SUB = 4'b0011
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       alu_sel_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo, d;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [WIDTH-1:0] shifted;
  logic             msb, carry, geq, last;

  // hi/lo double as rem/quo for divide; op[1] selects the divide datapath
  assign shifted = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign msb     = hi[WIDTH-1];
  assign carry   = alu_result_i < hi;
  assign geq     = msb | !(shifted < d);
  assign last    = count == CW'(WIDTH - 1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    alu_sel_o  = SEL_ADD;
    alu_a_o    = '0;
    alu_b_o    = '0;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      IDLE: if (start_i) state_next = RUN;
      RUN: begin
        busy_o  = 1'b1;
        alu_b_o = d;
        if (op[1]) begin
          alu_sel_o = SEL_SUB;
          alu_a_o   = shifted;
          hi_next   = geq ? alu_result_i : shifted;
          lo_next   = {lo[WIDTH-2:0], geq};
        end else begin
          alu_a_o = hi;
          if (lo[0]) {hi_next, lo_next} = {carry, alu_result_i, lo[WIDTH-1:1]};
          else       {hi_next, lo_next} = {1'b0, hi, lo[WIDTH-1:1]};
        end
        if (last) state_next = DONE;
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op       <= '0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      d        <= '0;
      result_o <= '0;
    end else if (state == IDLE) begin
      if (start_i) begin
        op    <= op_i;
        d     <= rs2_i;
        count <= '0;
        hi    <= '0;
        lo    <= rs1_i;
      end
    end else if (state == RUN) begin
      hi    <= hi_next;
      lo    <= lo_next;
      count <= count + CW'(1);
      // MULHU/REMU live in hi, MUL/DIVU in lo
      if (last) result_o <= op[0] ? hi_next : lo_next;
    end
  end

endmodule
